// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer/FIFO-side signal bundle for the round-robin FIFO write arbiter
interface fifo_wr_arbiter_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ    = 4
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_full;
    logic                          fifo_almostfull;
    logic                          fifo_wr_ack;
    logic                          fifo_overflow;
    logic                          fifo_wr_en;
    logic [FIFO_WIDTH-1:0]         fifo_data_in;
    logic [IDX_W-1:0]              owner;
    logic                          stall;
    logic                          ack_err;
    logic                          ovf_err;

    // Producers and FIFO side: drive requests and FIFO flags, observe grants and the write port
    modport master (
        output req, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
        input  gnt, fifo_wr_en, fifo_data_in, owner, stall, ack_err, ovf_err
    );

    // Arbiter side
    modport slave (
        input  req, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
        output gnt, fifo_wr_en, fifo_data_in, owner, stall, ack_err, ovf_err
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port among producers
module fifo_wr_arbiter #(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [3:0]       BURST_MAX = 4'(BURST_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, BURST, STALL} state_t;

    state_t                state;
    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      owner_q;
    logic [3:0]            burst_cnt;
    logic                  wr_en_q;
    logic [FIFO_WIDTH-1:0] data_q;
    logic                  stall_q;
    logic                  wr_en_d;
    logic                  ack_err_q;
    logic                  ovf_err_q;

    logic                  can_issue;
    logic                  keep;
    logic                  found;
    logic [IDX_W-1:0]      cand;
    logic [IDX_W-1:0]      winner;
    logic                  grant;
    logic                  renew;
    logic [IDX_W-1:0]      sel;
    logic [NUM_REQ-1:0]    gnt_c;
    logic [FIFO_WIDTH-1:0] sel_data;

    // A write already in flight will consume the last free slot, so almostfull blocks only then
    assign can_issue = !bus.fifo_full && !(bus.fifo_almostfull && wr_en_q);

    // The current owner keeps the port until its burst quota is spent or it stops requesting
    assign keep = (state != IDLE) && bus.req[owner_q] && (burst_cnt < BURST_MAX);

    // Rotating search: first active requester starting at ptr; lowest offset wins
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Grant decision and one-hot grant vector; nothing is granted while reset is held
    always_comb begin
        grant = 1'b0;
        renew = 1'b0;
        sel   = '0;
        gnt_c = '0;
        if (!rst && can_issue) begin
            if (keep) begin
                grant = 1'b1;
                sel   = owner_q;
            end else if (found) begin
                grant = 1'b1;
                renew = 1'b1;
                sel   = winner;
            end
        end
        if (grant) begin
            gnt_c[sel] = 1'b1;
        end
    end

    // Word of the selected requester
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == IDX_W'(i)) begin
                sel_data = bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    // Arbitration FSM with registered FIFO write port, owner, rotate pointer and stall flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner_q   <= '0;
            burst_cnt <= '0;
            wr_en_q   <= 1'b0;
            data_q    <= '0;
            stall_q   <= 1'b0;
        end else begin
            if (grant) begin
                wr_en_q <= 1'b1;
                data_q  <= sel_data;
                owner_q <= sel;
                if (renew) begin
                    ptr       <= (sel == LAST_IDX) ? '0 : sel + 1'b1;
                    burst_cnt <= 4'd1;
                end else begin
                    burst_cnt <= burst_cnt + 4'd1;
                end
            end else begin
                wr_en_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (grant) begin
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (!can_issue && bus.req[owner_q]) begin
                        state <= STALL;
                    end else if (can_issue && !grant) begin
                        state <= IDLE;
                    end
                end
                STALL: begin
                    if (can_issue) begin
                        state <= BURST;
                    end
                end
                default: state <= IDLE;
            endcase

            stall_q <= (state == STALL);
        end
    end

    // Sticky protocol checks: every write must be acked the following cycle; overflow never allowed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_d   <= 1'b0;
            ack_err_q <= 1'b0;
            ovf_err_q <= 1'b0;
        end else begin
            wr_en_d <= wr_en_q;
            if (wr_en_d && !bus.fifo_wr_ack) begin
                ack_err_q <= 1'b1;
            end
            if (bus.fifo_overflow) begin
                ovf_err_q <= 1'b1;
            end
        end
    end

    assign bus.gnt          = gnt_c;
    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_data_in = data_q;
    assign bus.owner        = owner_q;
    assign bus.stall        = stall_q;
    assign bus.ack_err      = ack_err_q;
    assign bus.ovf_err      = ovf_err_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.FIFO_WIDTH(16), .NUM_REQ(4)) bus ();
    fifo_wr_arbiter_if #(.FIFO_WIDTH(16), .NUM_REQ(4)) bus2 ();

    fifo_wr_arbiter #(.FIFO_WIDTH(16), .NUM_REQ(4), .BURST_LEN(4)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    fifo_wr_arbiter #(.FIFO_WIDTH(16), .NUM_REQ(4), .BURST_LEN(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    assign bus2.req             = bus.req;
    assign bus2.req_data        = bus.req_data;
    assign bus2.fifo_full       = bus.fifo_full;
    assign bus2.fifo_almostfull = bus.fifo_almostfull;
    assign bus2.fifo_wr_ack     = bus.fifo_wr_ack;
    assign bus2.fifo_overflow   = bus.fifo_overflow;

    // DEPTH-8 FIFO model fed by u_dut's write port
    logic rd;
    logic force_ovf;
    logic drop_ack;
    int   fcount;
    logic ack_q;
    logic ovf_q;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fcount <= 0;
            ack_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            fcount <= fcount + ((bus.fifo_wr_en && fcount < 8) ? 1 : 0) - ((rd && fcount > 0) ? 1 : 0);
            ack_q  <= bus.fifo_wr_en && (fcount < 8);
            ovf_q  <= bus.fifo_wr_en && (fcount == 8);
        end
    end

    assign bus.fifo_full       = (fcount == 8);
    assign bus.fifo_almostfull = (fcount >= 7);
    assign bus.fifo_wr_ack     = ack_q & ~drop_ack;
    assign bus.fifo_overflow   = ovf_q | force_ovf;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    int rr_seq[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int k;
    int grants;
    int writes;
    logic last_gnt;

    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        rd           = 1'b0;
        force_ovf    = 1'b0;
        drop_ack     = 1'b0;

        // Reset state and idle
        bus.req = 4'b1111;
        #2;
        check("gnt_in_rst", bus.gnt, 0);
        bus.req = '0;
        do_reset();
        for (int n = 0; n < 5; n++) begin
            #3;
            check("idle_gnt", bus.gnt, 0);
            check("idle_wr_en", bus.fifo_wr_en, 0);
            cyc();
        end
        check("idle_data", bus.fifo_data_in, 0);
        check("idle_owner", bus.owner, 0);
        check("idle_stall", bus.stall, 0);
        check("idle_ack_err", bus.ack_err, 0);
        check("idle_ovf_err", bus.ovf_err, 0);

        // Single requester 2, drained FIFO, back-to-back bursts
        rd = 1'b1;
        do_reset();
        k = 0;
        last_gnt = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (last_gnt) k++;
            bus.req = 4'b0100;
            bus.req_data[32 +: 16] = 16'hA000 + 16'(k);
            #3;
            check("single_gnt", bus.gnt, 4'b0100);
            if (n > 0) begin
                check("single_data", bus.fifo_data_in, 32'hA000 + 32'(n - 1));
                check("single_wr_en", bus.fifo_wr_en, 1);
                check("single_owner", bus.owner, 2);
            end
            last_gnt = bus.gnt[2];
            cyc();
        end
        bus.req = '0;
        cyc();
        cyc();
        check("single_ack_err", bus.ack_err, 0);

        // All four requesting from reset, BURST_LEN=2 instance
        bus.req = 4'b1111;
        do_reset();
        for (int n = 0; n < 10; n++) begin
            #3;
            check("rr_gnt", bus2.gnt, 4'b0001 << rr_seq[n]);
            cyc();
        end

        // Fill an undrained DEPTH-8 FIFO
        rd = 1'b0;
        bus.req = 4'b0100;
        do_reset();
        grants = 0;
        writes = 0;
        for (int n = 0; n < 14; n++) begin
            #3;
            if (bus.gnt[2]) grants++;
            if (bus.fifo_wr_en) writes++;
            if (bus.fifo_almostfull && bus.fifo_wr_en) check("no_gnt_af", bus.gnt, 0);
            cyc();
        end
        check("fill_grants", grants, 8);
        check("fill_writes", writes, 8);
        check("fill_full", bus.fifo_full, 1);
        check("fill_stall", bus.stall, 1);
        check("fill_ovf_err", bus.ovf_err, 0);
        rd = 1'b1;
        #3;
        cyc();
        rd = 1'b0;
        grants = 0;
        for (int n = 0; n < 5; n++) begin
            #3;
            if (bus.gnt[2]) grants++;
            cyc();
        end
        check("read_one_grant", grants, 1);
        check("fill_ack_err", bus.ack_err, 0);

        // Sticky error flags
        bus.req = '0;
        rd = 1'b1;
        do_reset();
        force_ovf = 1'b1;
        #3;
        cyc();
        force_ovf = 1'b0;
        #3;
        check("ovf_set", bus.ovf_err, 1);
        check("ovf_no_ack_err", bus.ack_err, 0);
        cyc();
        cyc();
        #3;
        check("ovf_sticky", bus.ovf_err, 1);
        bus.req = 4'b0001;
        #1;
        check("err_gnt", bus.gnt, 4'b0001);
        cyc();
        bus.req = '0;
        drop_ack = 1'b1;
        #3;
        cyc();
        #3;
        cyc();
        drop_ack = 1'b0;
        #3;
        check("ack_set", bus.ack_err, 1);
        cyc();
        cyc();
        #3;
        check("ack_sticky", bus.ack_err, 1);
        check("ovf_still", bus.ovf_err, 1);
        do_reset();
        #3;
        check("ack_cleared", bus.ack_err, 0);
        check("ovf_cleared", bus.ovf_err, 0);

        // Reset mid-burst with owner 1
        bus.req = 4'b0010;
        cyc();
        #3;
        cyc();
        #3;
        cyc();
        check("mid_owner", bus.owner, 1);
        check("mid_wr_en", bus.fifo_wr_en, 1);
        rst = 1'b1;
        #1;
        check("rst_wr_en", bus.fifo_wr_en, 0);
        check("rst_owner", bus.owner, 0);
        check("rst_ptr", u_dut.ptr, 0);
        check("rst_gnt", bus.gnt, 0);
        bus.req = 4'b0011;
        cyc();
        rst = 1'b0;
        #3;
        check("post_rst_gnt", bus.gnt, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
